ad9826_init_seq: RTL and testbench
==================================

# ad9826_init_seq

Power-up and on-demand register programmer for the AD9826 CCD front-end. Holds a shadow copy of the eight AD9826 registers, and on `start` writes them in ascending address order through the serial configuration port controller, one transaction at a time, using its `toggle` / `ad_sload` handshake. It sits directly upstream of the serial configuration port controller, and the host register interface feeds it.

## Interface
Parameters:
- `DEF_CONFIG`, 9'h058: reset value of shadow reg 0 (Configuration).
- `DEF_MUX`, 9'h0C0: reset value of shadow reg 1 (MUX config).
- `DEF_GAIN`, 9'h000: reset value of shadow regs 2–4 (R/G/B PGA gain).
- `DEF_OFFSET`, 9'h000: reset value of shadow regs 5–7 (R/G/B offset).
- `ACK_TIMEOUT`, 16'd4096: clk cycles allowed per wait state before abort.

Ports:
- `clk`, in, 1: system clock (100 MHz). Single clock domain.
- `reset`, in, 1: synchronous, active-high reset.
- `start`, in, 1: one-cycle request to program all eight registers.
- `host_we`, in, 1: shadow write strobe.
- `host_addr`, in, 3: shadow register index.
- `host_wdata`, in, 9: shadow write data.
- `host_rdata`, out, 9: shadow content at `host_addr`, combinational.
- `cfg_addr`, out, 4: to the controller. Bit 0 is 1 for write, 0 for read. Bits [3:1] are the register address.
- `cfg_data`, out, 9: write data to the controller.
- `cfg_toggle`, out, 1: one-cycle transaction launch.
- `cfg_idle`, in, 1: the controller's `ad_sload`. 1 means idle.
- `cfg_rdata`, in, 9: readback data from the controller.
- `busy`, out, 1: sequence in progress.
- `done`, out, 1: one-cycle pulse when the sequence completes without error.
- `error`, out, 1: sticky; cleared only by an accepted `start` or by `reset`.
- `err_reg`, out, 3: register index at which the abort occurred.

## Operation
- On reset:
  - Shadow registers load the `DEF_*` parameter values.
  - The FSM goes to IDLE.
  - `cfg_addr`=0, `cfg_data`=0, `cfg_toggle`=0, `busy`=0, `done`=0, `error`=0, `err_reg`=0.
- States: IDLE, LOAD, PULSE, WAIT_ACK, WAIT_IDLE, NEXT, FINISH. READ and CHECK exist only with the readback feature.
- IDLE:
  - `start`=1 clears `error`, sets `idx`=0 and moves to LOAD.
  - `host_we`=1 writes `shadow[host_addr]`.
- LOAD: sets `cfg_addr`={`idx`,1'b1} and `cfg_data`=`shadow[idx]`. Requires `cfg_idle`=1, otherwise stays (timeout applies). Then moves to PULSE.
- PULSE: `cfg_toggle`=1 for exactly one cycle, then WAIT_ACK.
- WAIT_ACK: waits for `cfg_idle`=0, then WAIT_IDLE.
- WAIT_IDLE: waits for `cfg_idle`=1, then NEXT, or READ with the readback feature.
- NEXT: if `idx`==7, go to FINISH; otherwise increment `idx` and go to LOAD.
- FINISH: `done`=1 for one cycle, then IDLE.
- Timeout:
  - A 16-bit counter resets on every state entry.
  - If a wait state reaches `ACK_TIMEOUT`, the block sets `error`=1 and `err_reg`=`idx`, then returns to IDLE.
  - No `done` pulse is issued on abort.
- While `busy`:
  - `start` is ignored.
  - `host_we` is ignored and shadow contents are unchanged.
- `busy`=1 in every state except IDLE. It deasserts in the same cycle the FSM enters IDLE.
- `reset` mid-sequence aborts immediately. Shadow returns to defaults and `cfg_toggle` is never left high.

## Timing
- `start` to the first `cfg_toggle`: 2 cycles (LOAD, then PULSE), given `cfg_idle`=1.
- `cfg_addr` and `cfg_data` are registered outputs. They are held constant from LOAD until the state after WAIT_IDLE, covering the whole serial transaction.
- Per-register cost is 4 cycles plus the controller's busy time (about 16 serial clocks at 6.25 MHz, roughly 256 clk).
- `done` rises the cycle after NEXT at `idx`=7.
- `host_rdata` is valid in the same cycle as `host_addr`.
- A `host_we` and a `start` in the same IDLE cycle: the write commits first, and the sequence sends the new value.

## Configuration
- Macro: `AD9826_READBACK_EN`.
- When defined, after WAIT_IDLE for each register the block runs:
  - READ: `cfg_addr`={`idx`,1'b0}, then one `cfg_toggle` cycle, then WAIT_ACK and WAIT_IDLE again.
  - CHECK: if `cfg_rdata` != `shadow[idx]`, set `error`=1 and `err_reg`=`idx`, then go to IDLE. Otherwise go to NEXT.
- When undefined:
  - The READ and CHECK states are absent.
  - `cfg_rdata` is unused.
  - `error` can only be set by timeout.

## Test plan
- Reset, then `start` with a model controller holding `cfg_idle` low for 200 cycles per toggle:
  - Exactly 8 toggles occur, with `cfg_addr` = 1, 3, 5, …, F.
  - `cfg_data` = 058, 0C0, 000 ×6.
  - One `done` pulse; `error`=0.
- Write `host_addr`=3 with `host_wdata`=9'h1A5, then `start`:
  - The fourth transaction has `cfg_data`=9'h1A5.
  - `host_rdata` reads 9'h1A5.
- The model never drops `cfg_idle` after the third toggle:
  - `error`=1 and `err_reg`=2 after `ACK_TIMEOUT` cycles.
  - No `done`; `busy`=0.
- `start` and `host_we` pulsed mid-sequence:
  - No restart.
  - The shadow value is unchanged.
  - Toggle count is still 8.
- Assert `reset` during WAIT_IDLE of register 4:
  - All outputs return to 0 the next cycle.
  - Shadow returns to the defaults.
- With `AD9826_READBACK_EN` and the model returning 9'h001 for register 1:
  - 4 toggles total (write 0, read 0, write 1, read 1).
  - `error`=1 and `err_reg`=1.

Source files
------------

// File: rtl/ad9826_init_seq_if.sv
// -----------------------------------------------------------------------------
// ad9826_init_seq_if
//
// Transaction bus between the AD9826 register programmer and the serial
// configuration port controller.
//
// Signals:
//   cfg_addr   [3:0]  {reg_addr[2:0], write_not_read}, driven by the programmer
//   cfg_data   [8:0]  write data, driven by the programmer
//   cfg_toggle        one-cycle transaction launch, driven by the programmer
//   cfg_idle          controller ad_sload, 1 = controller idle
//   cfg_rdata  [8:0]  readback data returned by the controller
//
// Modports:
//   master  - the register programmer (ad9826_init_seq)
//   slave   - the serial configuration port controller
// -----------------------------------------------------------------------------
interface ad9826_init_seq_if;
   logic [3:0] cfg_addr;
   logic [8:0] cfg_data;
   logic       cfg_toggle;
   logic       cfg_idle;
   logic [8:0] cfg_rdata;

   modport master (
      output cfg_addr,
      output cfg_data,
      output cfg_toggle,
      input  cfg_idle,
      input  cfg_rdata
   );

   modport slave (
      input  cfg_addr,
      input  cfg_data,
      input  cfg_toggle,
      output cfg_idle,
      output cfg_rdata
   );
endinterface

// File: rtl/ad9826_init_seq.sv
// -----------------------------------------------------------------------------
// ad9826_init_seq
//
// Power-up / on-demand register programmer for the AD9826 CCD front-end.
// Keeps a shadow copy of the eight AD9826 registers (host read/write while
// idle) and, on start, writes them in ascending address order through the
// serial configuration port controller, one transaction at a time, using the
// cfg_toggle / cfg_idle (ad_sload) handshake. Every wait on the controller is
// bounded by ACK_TIMEOUT clk cycles; an expired wait aborts the sequence and
// latches a sticky error together with the register index.
//
// Optional feature (macro AD9826_READBACK_EN): after each write the register
// is read back and compared against the shadow value; a difference aborts
// the sequence with error/err_reg set.
//
// Ports:
//   clk         system clock (100 MHz), single domain
//   reset       synchronous, active-high
//   start       one-cycle request to program all eight registers
//   host_we     shadow write strobe (honoured only while idle)
//   host_addr   shadow register index
//   host_wdata  shadow write data
//   host_rdata  shadow content at host_addr (combinational)
//   cfg         transaction bus to the serial port controller (master side)
//   busy        sequence in progress (every state except IDLE)
//   done        one-cycle pulse on error-free completion
//   error       sticky abort flag, cleared by an accepted start or reset
//   err_reg     register index at which the abort occurred
// -----------------------------------------------------------------------------
module ad9826_init_seq #(
   parameter logic [8:0]  DEF_CONFIG  = 9'h058,
   parameter logic [8:0]  DEF_MUX     = 9'h0C0,
   parameter logic [8:0]  DEF_GAIN    = 9'h000,
   parameter logic [8:0]  DEF_OFFSET  = 9'h000,
   parameter logic [15:0] ACK_TIMEOUT = 16'd4096
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     start,
   input  logic                     host_we,
   input  logic [2:0]               host_addr,
   input  logic [8:0]               host_wdata,
   output logic [8:0]               host_rdata,
   ad9826_init_seq_if.master        cfg,
   output logic                     busy,
   output logic                     done,
   output logic                     error,
   output logic [2:0]               err_reg
);

   typedef enum logic [3:0] {
      IDLE,
      LOAD,
      PULSE,
      WAIT_ACK,
      WAIT_IDLE,
      NEXT,
      FINISH
`ifdef AD9826_READBACK_EN
      ,
      READ,
      CHECK
`endif
   } state_t;

   state_t      state_q, state_d;
   logic [2:0]  idx_q;
   logic [15:0] tmr_q;
   logic [3:0]  cfg_addr_q;
   logic [8:0]  cfg_data_q;
   logic        error_q;
   logic [2:0]  err_reg_q;
   logic [8:0]  shadow [0:7];

   // Control strobes produced by the next-state logic
   logic        idx_clr;
   logic        idx_inc;
   logic        ld_wr;
   logic        clr_err;
   logic        set_err;
   logic        timeout;

`ifdef AD9826_READBACK_EN
   logic        rd_phase_q;
   logic        ld_rd;
`else
   // Readback data has no consumer without the readback feature
   logic        unused_rdata;
   assign unused_rdata = ^cfg.cfg_rdata;
`endif

   // Power-up / reset content of each shadow register
   function automatic logic [8:0] shadow_default(input int i);
      case (i)
         0:       return DEF_CONFIG;
         1:       return DEF_MUX;
         2, 3, 4: return DEF_GAIN;
         default: return DEF_OFFSET;
      endcase
   endfunction

   // The timer restarts on every state entry, so reaching ACK_TIMEOUT-1 means
   // this is the ACK_TIMEOUT-th cycle spent waiting in the current state.
   assign timeout = (tmr_q == ACK_TIMEOUT - 16'd1);

   // ---------------------------------------------------------------------------
   // Next-state and control decode
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      idx_clr = 1'b0;
      idx_inc = 1'b0;
      ld_wr   = 1'b0;
      clr_err = 1'b0;
      set_err = 1'b0;
`ifdef AD9826_READBACK_EN
      ld_rd   = 1'b0;
`endif

      case (state_q)
         IDLE: begin
            if (start) begin
               clr_err = 1'b1;
               idx_clr = 1'b1;
               state_d = LOAD;
            end
         end

         // Address/data are captured on the way out of LOAD so they are
         // already stable in the cycle cfg_toggle is raised.
         LOAD: begin
            if (cfg.cfg_idle) begin
               ld_wr   = 1'b1;
               state_d = PULSE;
            end else if (timeout) begin
               set_err = 1'b1;
               state_d = IDLE;
            end
         end

         PULSE: state_d = WAIT_ACK;

         WAIT_ACK: begin
            if (!cfg.cfg_idle) begin
               state_d = WAIT_IDLE;
            end else if (timeout) begin
               set_err = 1'b1;
               state_d = IDLE;
            end
         end

         WAIT_IDLE: begin
            if (cfg.cfg_idle) begin
`ifdef AD9826_READBACK_EN
               state_d = rd_phase_q ? CHECK : READ;
`else
               state_d = NEXT;
`endif
            end else if (timeout) begin
               set_err = 1'b1;
               state_d = IDLE;
            end
         end

`ifdef AD9826_READBACK_EN
         // Controller was just seen idle, so the read can launch directly;
         // PULSE/WAIT_ACK/WAIT_IDLE are shared with the write transaction.
         READ: begin
            ld_rd   = 1'b1;
            state_d = PULSE;
         end

         CHECK: begin
            if (cfg.cfg_rdata != shadow[idx_q]) begin
               set_err = 1'b1;
               state_d = IDLE;
            end else begin
               state_d = NEXT;
            end
         end
`endif

         NEXT: begin
            if (idx_q == 3'd7) begin
               state_d = FINISH;
            end else begin
               idx_inc = 1'b1;
               state_d = LOAD;
            end
         end

         FINISH: state_d = IDLE;

         default: state_d = IDLE;
      endcase
   end

   // ---------------------------------------------------------------------------
   // Sequencer state, timer, transaction registers and error flags
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         idx_q      <= 3'd0;
         tmr_q      <= 16'd0;
         cfg_addr_q <= 4'd0;
         cfg_data_q <= 9'd0;
         error_q    <= 1'b0;
         err_reg_q  <= 3'd0;
      end else begin
         state_q <= state_d;

         if (state_d != state_q || state_q == IDLE) begin
            tmr_q <= 16'd0;
         end else begin
            tmr_q <= tmr_q + 16'd1;
         end

         if (idx_clr) begin
            idx_q <= 3'd0;
         end else if (idx_inc) begin
            idx_q <= idx_q + 3'd1;
         end

         if (ld_wr) begin
            cfg_addr_q <= {idx_q, 1'b1};
            cfg_data_q <= shadow[idx_q];
         end
`ifdef AD9826_READBACK_EN
         else if (ld_rd) begin
            cfg_addr_q <= {idx_q, 1'b0};
         end
`endif

         if (clr_err) begin
            error_q <= 1'b0;
         end else if (set_err) begin
            error_q   <= 1'b1;
            err_reg_q <= idx_q;
         end
      end
   end

`ifdef AD9826_READBACK_EN
   // Distinguishes the write and the readback pass through the shared
   // PULSE/WAIT_ACK/WAIT_IDLE states.
   always_ff @(posedge clk) begin
      if (reset) begin
         rd_phase_q <= 1'b0;
      end else if (idx_clr || ld_wr) begin
         rd_phase_q <= 1'b0;
      end else if (ld_rd) begin
         rd_phase_q <= 1'b1;
      end
   end
`endif

   // ---------------------------------------------------------------------------
   // Shadow register file; host writes only land while the sequencer is idle,
   // so a write and a start in the same cycle send the new value.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 8; i++) begin
            shadow[i] <= shadow_default(i);
         end
      end else if (host_we && state_q == IDLE) begin
         shadow[host_addr] <= host_wdata;
      end
   end

   assign host_rdata     = shadow[host_addr];

   assign cfg.cfg_addr   = cfg_addr_q;
   assign cfg.cfg_data   = cfg_data_q;
   assign cfg.cfg_toggle = (state_q == PULSE);

   assign busy    = (state_q != IDLE);
   assign done    = (state_q == FINISH);
   assign error   = error_q;
   assign err_reg = err_reg_q;

endmodule

// File: tb/tb_ad9826_init_seq.sv
// -----------------------------------------------------------------------------
// tb_ad9826_init_seq
//
// Directed bench for ad9826_init_seq. A behavioural serial-port controller
// model answers each cfg_toggle by holding cfg_idle low for 200 cycles and
// logs every launched transaction; it can be told to never acknowledge a
// given toggle. With AD9826_READBACK_EN defined the model returns the last
// written value on reads, except 9'h001 for register 1.
// -----------------------------------------------------------------------------
module tb_ad9826_init_seq;

   logic       clk = 1'b0;
   logic       reset;
   logic       start;
   logic       host_we;
   logic [2:0] host_addr;
   logic [8:0] host_wdata;
   logic [8:0] host_rdata;
   logic       busy;
   logic       done;
   logic       error;
   logic [2:0] err_reg;

   ad9826_init_seq_if bus ();

   ad9826_init_seq dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .host_we    (host_we),
      .host_addr  (host_addr),
      .host_wdata (host_wdata),
      .host_rdata (host_rdata),
      .cfg        (bus),
      .busy       (busy),
      .done       (done),
      .error      (error),
      .err_reg    (err_reg)
   );

   always #5 clk = ~clk;

   // ---------------- controller model ----------------
   logic       m_idle;
   logic [8:0] m_rdata;
   logic [8:0] m_last;
   int         m_cnt;
   int         tog_cnt = 0;
   int         hang_at = 1000;
   logic [3:0] log_addr [0:63];
   logic [8:0] log_data [0:63];

   assign bus.cfg_idle  = m_idle;
   assign bus.cfg_rdata = m_rdata;

   always @(posedge clk) begin
      if (reset) begin
         m_idle  <= 1'b1;
         m_cnt   <= 0;
         m_rdata <= 9'd0;
         m_last  <= 9'd0;
      end else if (bus.cfg_toggle === 1'b1) begin
         log_addr[tog_cnt & 63] <= bus.cfg_addr;
         log_data[tog_cnt & 63] <= bus.cfg_data;
         tog_cnt <= tog_cnt + 1;
         if (bus.cfg_addr[0]) begin
            m_last <= bus.cfg_data;
         end else begin
            m_rdata <= (bus.cfg_addr[3:1] == 3'd1) ? 9'h001 : m_last;
         end
         if (tog_cnt != hang_at) begin
            m_idle <= 1'b0;
            m_cnt  <= 200;
         end
      end else if (m_cnt != 0) begin
         m_cnt <= m_cnt - 1;
         if (m_cnt == 1) m_idle <= 1'b1;
      end
   end

   // ---------------- checking helpers ----------------
   int n_cmp = 0;
   int n_mis = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic run_to_idle(input int limit, output int dones, output int cycles);
      dones  = 0;
      cycles = 0;
      while (busy === 1'b1 && cycles < limit) begin
         @(negedge clk);
         cycles++;
         if (done === 1'b1) dones++;
      end
      check("seq_within_budget", {31'd0, busy}, 32'd0);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick(1);
      start = 1'b0;
   endtask

   logic [8:0] exp_d [0:7];

   task automatic check_log(input int base);
      for (int i = 0; i < 8; i++) begin
         check($sformatf("tx%0d_addr", i), log_addr[(base + i) & 63], 2 * i + 1);
         check($sformatf("tx%0d_data", i), log_data[(base + i) & 63], exp_d[i]);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, summary: %0d compared / %0d mismatched", n_cmp, n_mis);
      $fatal(1, "watchdog");
   end

   // ---------------- directed sequence ----------------
   initial begin
      int base;
      int dones;
      int cyc;
      int k;

      reset      = 1'b1;
      start      = 1'b0;
      host_we    = 1'b0;
      host_addr  = 3'd0;
      host_wdata = 9'd0;
      exp_d[0] = 9'h058; exp_d[1] = 9'h0C0;
      for (int i = 2; i < 8; i++) exp_d[i] = 9'h000;

      tick(3);
      check("rst_busy",   busy,           0);
      check("rst_done",   done,           0);
      check("rst_error",  error,          0);
      check("rst_errreg", err_reg,        0);
      check("rst_toggle", bus.cfg_toggle, 0);
      check("rst_addr",   bus.cfg_addr,   0);
      check("rst_data",   bus.cfg_data,   0);
      host_addr = 3'd0; #1 check("rst_shadow0", host_rdata, 9'h058);
      host_addr = 3'd1; #1 check("rst_shadow1", host_rdata, 9'h0C0);
      host_addr = 3'd7; #1 check("rst_shadow7", host_rdata, 9'h000);
      reset = 1'b0;
      tick(2);

`ifdef AD9826_READBACK_EN
      // Readback mismatch on register 1
      base = tog_cnt;
      pulse_start();
      run_to_idle(5000, dones, cyc);
      check("rb_toggles", tog_cnt - base, 4);
      check("rb_error",   error,   1);
      check("rb_errreg",  err_reg, 1);
      check("rb_no_done", dones,   0);
      check("rb_seq0", log_addr[(base + 0) & 63], 4'h1);
      check("rb_seq1", log_addr[(base + 1) & 63], 4'h0);
      check("rb_seq2", log_addr[(base + 2) & 63], 4'h3);
      check("rb_seq3", log_addr[(base + 3) & 63], 4'h2);
`else
      // Full default sequence, with start-to-toggle latency
      base = tog_cnt;
      pulse_start();
      check("lat_load_toggle", bus.cfg_toggle, 0);
      check("lat_load_busy",   busy,           1);
      tick(1);
      check("lat_pulse_toggle", bus.cfg_toggle, 1);
      check("lat_pulse_addr",   bus.cfg_addr,   4'h1);
      check("lat_pulse_data",   bus.cfg_data,   9'h058);
      run_to_idle(5000, dones, cyc);
      check("t1_toggles", tog_cnt - base, 8);
      check("t1_dones",   dones, 1);
      check("t1_error",   error, 0);
      check_log(base);

      // Host write of register 3, then sequence
      host_addr = 3'd3; host_wdata = 9'h1A5; host_we = 1'b1;
      tick(1);
      host_we = 1'b0;
      #1 check("t2_rdata", host_rdata, 9'h1A5);
      exp_d[3] = 9'h1A5;
      base = tog_cnt;
      pulse_start();
      run_to_idle(5000, dones, cyc);
      check("t2_toggles", tog_cnt - base, 8);
      check("t2_dones",   dones, 1);
      check("t2_tx3_data", log_data[(base + 3) & 63], 9'h1A5);

      // Controller never acknowledges the third toggle
      base    = tog_cnt;
      hang_at = base + 2;
      pulse_start();
      run_to_idle(6000, dones, cyc);
      check("t3_error",   error,   1);
      check("t3_errreg",  err_reg, 2);
      check("t3_no_done", dones,   0);
      check("t3_busy",    busy,    0);
      check("t3_toggles", tog_cnt - base, 3);
      check("t3_span", {31'd0, (cyc >= 4096 && cyc < 4800)}, 1);
      hang_at = 1000;
      tick(5);
      check("t3_sticky", error, 1);

      // Write + start in the same cycle, then start/host_we mid-sequence
      base = tog_cnt;
      host_addr = 3'd5; host_wdata = 9'h0AB; host_we = 1'b1; start = 1'b1;
      tick(1);
      host_we = 1'b0; start = 1'b0;
      check("t4_err_cleared", error, 0);
      exp_d[5] = 9'h0AB;
      tick(50);
      check("t4_busy_mid", busy, 1);
      host_addr = 3'd2; host_wdata = 9'h1FF; host_we = 1'b1; start = 1'b1;
      tick(1);
      host_we = 1'b0; start = 1'b0;
      #1 check("t4_shadow_kept", host_rdata, 9'h000);
      run_to_idle(5000, dones, cyc);
      check("t4_toggles", tog_cnt - base, 8);
      check("t4_dones",   dones, 1);
      check("t4_error",   error, 0);
      check_log(base);

      // Reset during WAIT_IDLE of register 4
      base = tog_cnt;
      pulse_start();
      k = 0;
      while (tog_cnt < base + 5 && k < 5000) begin
         tick(1);
         k++;
      end
      check("t5_reached_reg4", {31'd0, (tog_cnt >= base + 5)}, 1);
      tick(10);
      check("t5_busy_before", busy, 1);
      reset = 1'b1;
      tick(1);
      check("t5_busy",   busy,           0);
      check("t5_done",   done,           0);
      check("t5_toggle", bus.cfg_toggle, 0);
      check("t5_addr",   bus.cfg_addr,   0);
      check("t5_data",   bus.cfg_data,   0);
      check("t5_error",  error,          0);
      check("t5_errreg", err_reg,        0);
      host_addr = 3'd3; #1 check("t5_shadow3", host_rdata, 9'h000);
      host_addr = 3'd5; #1 check("t5_shadow5", host_rdata, 9'h000);
      host_addr = 3'd0; #1 check("t5_shadow0", host_rdata, 9'h058);
      reset = 1'b0;
      tick(2);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
